// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: circle-engine handshake/pixel bus and VGA adapter write port.
// master = sequencer side, slave = circle engine / VGA adapter side.
interface draw_sequencer_if;
  logic       circ_start;
  logic [2:0] circ_colour;
  logic [7:0] circ_cx;
  logic [6:0] circ_cy;
  logic [7:0] circ_radius;
  logic       circ_done;
  logic [7:0] circ_x;
  logic [6:0] circ_y;
  logic       circ_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output circ_start, circ_colour, circ_cx, circ_cy, circ_radius,
    output vga_x, vga_y, vga_colour, vga_plot,
    input  circ_done, circ_x, circ_y, circ_plot
  );

  modport slave (
    input  circ_start, circ_colour, circ_cx, circ_cy, circ_radius,
    input  vga_x, vga_y, vga_colour, vga_plot,
    output circ_done, circ_x, circ_y, circ_plot
  );
endinterface

// File: rtl/draw_sequencer.sv
// draw_sequencer: optionally clears the framebuffer, then hands the VGA write port to the circle engine.
// Define DRAW_SEQ_CLEAR_EN to include the background clear phase.
module draw_sequencer #(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             colour,
  input  logic [7:0]             centre_x,
  input  logic [6:0]             centre_y,
  input  logic [7:0]             radius,
  output logic                   done,
  draw_sequencer_if.master       bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

  state_t     state;
  logic [2:0] colour_q;
  logic [7:0] cx_q;
  logic [6:0] cy_q;
  logic [7:0] radius_q;
  // Clear counters while clearing; afterwards they track the last circle pixel so DONE can hold it.
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic       circ_start_q;
  logic       done_q;

`ifdef DRAW_SEQ_CLEAR_EN
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
`else
  wire unused_cfg = ^{8'(SCREEN_W), 7'(SCREEN_H), BG_COLOUR};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      colour_q     <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      radius_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      circ_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            colour_q <= colour;
            cx_q     <= centre_x;
            cy_q     <= centre_y;
            radius_q <= radius;
            x_q      <= '0;
            y_q      <= '0;
`ifdef DRAW_SEQ_CLEAR_EN
            state    <= CLEAR;
`else
            state        <= DRAW;
            circ_start_q <= 1'b1;
`endif
          end
        end
`ifdef DRAW_SEQ_CLEAR_EN
        // y is the inner loop; the edge retiring the last pixel hands over to the circle engine.
        CLEAR: begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state        <= DRAW;
            circ_start_q <= 1'b1;
          end else if (y_q == Y_LAST) begin
            y_q <= '0;
            x_q <= x_q + 8'd1;
          end else begin
            y_q <= y_q + 7'd1;
          end
        end
`endif
        DRAW: begin
          x_q <= bus.circ_x;
          y_q <= bus.circ_y;
          if (bus.circ_done) begin
            state        <= DONE;
            circ_start_q <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign done            = done_q;
  assign bus.circ_start  = circ_start_q;
  assign bus.circ_colour = colour_q;
  assign bus.circ_cx     = cx_q;
  assign bus.circ_cy     = cy_q;
  assign bus.circ_radius = radius_q;

  // Write-port mux: only one source can own the port, selected purely by state.
  always_comb begin
    bus.vga_x      = x_q;
    bus.vga_y      = y_q;
    bus.vga_colour = colour_q;
    bus.vga_plot   = 1'b0;
    case (state)
`ifdef DRAW_SEQ_CLEAR_EN
      CLEAR: begin
        bus.vga_colour = BG_COLOUR;
        bus.vga_plot   = 1'b1;
      end
`endif
      DRAW: begin
        bus.vga_x    = bus.circ_x;
        bus.vga_y    = bus.circ_y;
        bus.vga_plot = bus.circ_plot;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: randomized self-checking bench; the bench itself plays the circle engine.
// Clear-phase checks are compiled in when DRAW_SEQ_CLEAR_EN is defined.
module tb_draw_sequencer;
  localparam int W = 160;
  localparam int H = 120;
`ifdef DRAW_SEQ_CLEAR_EN
  localparam int NRAND = 2;
`else
  localparam int NRAND = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] colour = '0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] qx[$];
  logic [6:0] qy[$];

  draw_sequencer_if bus();

  draw_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_pt(input int x, input int y);
    qx.push_back(8'(x));
    qy.push_back(7'(y));
  endtask

  // Midpoint circle: the pixel set the circle engine would emit, in octant order.
  task automatic build_circle(input int cx, input int cy, input int r);
    int px, py, d;
    qx.delete();
    qy.delete();
    px = r; py = 0; d = 1 - r;
    while (py <= px) begin
      add_pt(cx + px, cy + py); add_pt(cx - px, cy + py);
      add_pt(cx + px, cy - py); add_pt(cx - px, cy - py);
      add_pt(cx + py, cy + px); add_pt(cx - py, cy + px);
      add_pt(cx + py, cy - px); add_pt(cx - py, cy - px);
      py++;
      if (d <= 0) d += 2 * py + 1;
      else begin
        px--;
        d += 2 * (py - px) + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; bus.circ_done = 1'b0; bus.circ_plot = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic apply_start(input logic [2:0] c, input logic [7:0] x, input logic [6:0] y,
                             input logic [7:0] r);
    colour = c; centre_x = x; centre_y = y; radius = r; start = 1'b1;
    tick();
    start = 1'b0;
    colour = 3'($urandom); centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom);
  endtask

  task automatic test_reset();
    start = 1'b1; bus.circ_plot = 1'b1; bus.circ_x = 8'hAA; bus.circ_y = 7'h55; bus.circ_done = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({done, bus.circ_start, bus.vga_plot, bus.vga_x, bus.vga_y} !== {1'b0, 1'b0, 1'b0, 8'd0, 7'd0}) begin
      errors++;
      $display("FAIL reset_outputs got done=%0b cs=%0b plot=%0b x=%0d y=%0d want all 0",
               done, bus.circ_start, bus.vga_plot, bus.vga_x, bus.vga_y);
    end
    vectors++;
    if (bus.vga_colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_colour got %0d want 0", bus.vga_colour);
    end
    start = 1'b0; bus.circ_plot = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    vectors++;
    if ({done, bus.circ_start, bus.vga_plot} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got done=%0b cs=%0b plot=%0b want 000",
               done, bus.circ_start, bus.vga_plot);
    end
  endtask

  task automatic test_draw(input logic [2:0] c, input logic [7:0] cx, input logic [6:0] cy,
                           input logic [7:0] r);
    int         nfail, nplot, gaps;
    logic       pp;
    logic [7:0] px, lx;
    logic [6:0] py, ly;
    do_reset();
    build_circle(int'(cx), int'(cy), int'(r));
    bus.circ_plot = 1'b0; bus.circ_done = 1'b0;
    apply_start(c, cx, cy, r);
`ifdef DRAW_SEQ_CLEAR_EN
    nfail = 0;
    for (int i = 0; i < W * H; i++) begin
      bus.circ_plot = 1'($urandom); bus.circ_done = 1'($urandom);
      bus.circ_x = 8'($urandom); bus.circ_y = 7'($urandom);
      if (i == 500) begin
        start = 1'b1; colour = 3'($urandom); centre_x = 8'($urandom);
      end else start = 1'b0;
      #1;
      vectors++;
      if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.circ_start, done} !==
          {1'b1, 8'(i / H), 7'(i % H), 3'b000, 1'b0, 1'b0}) begin
        errors++; nfail++;
        $display("FAIL clear_px%0d got plot=%0b (%0d,%0d) c=%0d cs=%0b done=%0b want plot=1 (%0d,%0d) c=0",
                 i, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.circ_start, done, i / H, i % H);
      end
      if (nfail >= 8) break;
      tick();
    end
    start = 1'b0;
`endif
    bus.circ_plot = 1'b0; bus.circ_done = 1'b0; #1;
    vectors++;
    if ({bus.circ_start, bus.vga_plot, done} !== 3'b100) begin
      errors++;
      $display("FAIL draw_entry got cs=%0b plot=%0b done=%0b want cs=1 plot=0 done=0",
               bus.circ_start, bus.vga_plot, done);
    end
    vectors++;
    if ({bus.circ_colour, bus.circ_cx, bus.circ_cy, bus.circ_radius} !== {c, cx, cy, r}) begin
      errors++;
      $display("FAIL latched_params got c=%0d cx=%0d cy=%0d r=%0d want c=%0d cx=%0d cy=%0d r=%0d",
               bus.circ_colour, bus.circ_cx, bus.circ_cy, bus.circ_radius, c, cx, cy, r);
    end
    tick();
    nplot = 0;
    foreach (qx[k]) begin
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g <= gaps; g++) begin
        pp = (g == gaps);
        px = pp ? qx[k] : 8'($urandom);
        py = pp ? qy[k] : 7'($urandom);
        bus.circ_plot = pp; bus.circ_x = px; bus.circ_y = py;
        #1;
        vectors++;
        if (bus.vga_plot === 1'b1) nplot++;
        if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.circ_start, done} !==
            {pp, px, py, c, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL draw_pt%0d got plot=%0b (%0d,%0d) c=%0d cs=%0b done=%0b want plot=%0b (%0d,%0d) c=%0d",
                   k, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.circ_start, done, pp, px, py, c);
        end
        tick();
      end
    end
    lx = 8'($urandom); ly = 7'($urandom);
    bus.circ_plot = 1'b0; bus.circ_x = lx; bus.circ_y = ly; bus.circ_done = 1'b1;
    #1;
    vectors++;
    if ({done, bus.vga_plot} !== 2'b00) begin
      errors++;
      $display("FAIL done_early got done=%0b plot=%0b want 0 0", done, bus.vga_plot);
    end
    vectors++;
    if (nplot != qx.size()) begin
      errors++;
      $display("FAIL plot_count got %0d want %0d", nplot, qx.size());
    end
    tick();
    bus.circ_plot = 1'b1; bus.circ_x = 8'($urandom); bus.circ_y = 7'($urandom);
    #1;
    vectors++;
    if ({done, bus.circ_start, bus.vga_plot, bus.vga_x, bus.vga_y} !== {1'b1, 1'b0, 1'b0, lx, ly}) begin
      errors++;
      $display("FAIL done_state got done=%0b cs=%0b plot=%0b (%0d,%0d) want done=1 cs=0 plot=0 (%0d,%0d)",
               done, bus.circ_start, bus.vga_plot, bus.vga_x, bus.vga_y, lx, ly);
    end
    tick();
    start = 1'b1; colour = 3'($urandom);
    tick();
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      vectors++;
      if ({done, bus.circ_start, bus.vga_plot} !== 3'b100) begin
        errors++;
        $display("FAIL start_in_done%0d got done=%0b cs=%0b plot=%0b want 1 0 0",
                 j, done, bus.circ_start, bus.vga_plot);
      end
      tick();
    end
    bus.circ_plot = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    apply_start(3'b101, 8'd10, 7'd20, 8'd5);
`ifdef DRAW_SEQ_CLEAR_EN
    repeat (1000) tick();
    #1;
    vectors++;
    if ({bus.vga_plot, bus.vga_x, bus.vga_y} !== {1'b1, 8'(1000 / H), 7'(1000 % H)}) begin
      errors++;
      $display("FAIL clear_px1000 got plot=%0b (%0d,%0d) want 1 (%0d,%0d)",
               bus.vga_plot, bus.vga_x, bus.vga_y, 1000 / H, 1000 % H);
    end
`else
    bus.circ_x = 8'd33; bus.circ_y = 7'd44; bus.circ_plot = 1'b1;
    tick(); tick();
    vectors++;
    if ({bus.vga_plot, bus.vga_x, bus.vga_y} !== {1'b1, 8'd33, 7'd44}) begin
      errors++;
      $display("FAIL mid_draw got plot=%0b (%0d,%0d) want 1 (33,44)", bus.vga_plot, bus.vga_x, bus.vga_y);
    end
`endif
    #1;
    bus.circ_plot = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.vga_plot, bus.circ_start, done, bus.vga_x, bus.vga_y} !== {1'b0, 1'b0, 1'b0, 8'd0, 7'd0}) begin
      errors++;
      $display("FAIL mid_reset got plot=%0b cs=%0b done=%0b (%0d,%0d) want all 0",
               bus.vga_plot, bus.circ_start, done, bus.vga_x, bus.vga_y);
    end
    tick();
    rst_n = 1'b1; bus.circ_plot = 1'b0;
    tick();
    apply_start(3'b011, 8'd1, 7'd2, 8'd3);
`ifdef DRAW_SEQ_CLEAR_EN
    for (int j = 0; j < 2; j++) begin
      vectors++;
      if ({bus.vga_plot, bus.vga_x, bus.vga_y} !== {1'b1, 8'd0, 7'(j)}) begin
        errors++;
        $display("FAIL restart_px%0d got plot=%0b (%0d,%0d) want 1 (0,%0d)",
                 j, bus.vga_plot, bus.vga_x, bus.vga_y, j);
      end
      tick();
    end
`else
    vectors++;
    if ({bus.circ_start, bus.vga_plot} !== 2'b10) begin
      errors++;
      $display("FAIL restart got cs=%0b plot=%0b want cs=1 plot=0", bus.circ_start, bus.vga_plot);
    end
`endif
  endtask

  task automatic test_random_draws();
    for (int n = 0; n < NRAND; n++)
      test_draw(3'($urandom), 8'($urandom_range(20, 140)), 7'($urandom_range(20, 100)),
                8'($urandom_range(1, 30)));
  endtask

  initial begin
    bus.circ_done = 1'b0; bus.circ_plot = 1'b0; bus.circ_x = '0; bus.circ_y = '0;
    #1;
    test_reset();
    test_draw(3'b010, 8'd80, 7'd60, 8'd10);
    test_mid_reset();
    test_random_draws();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
